// File: rtl/queue_slot_alloc.sv
// queue_slot_alloc: write-side slot manager for the slot-based queue.
// Owns the occupancy bitmap, grants free slots round-robin on the write side
// and releases slots selected one-hot by the read side.

`ifndef QUEUE_DEPTH
`define QUEUE_DEPTH 8
`endif

module queue_slot_alloc #(
    parameter int unsigned QUEUE_DEPTH = `QUEUE_DEPTH,
    parameter int unsigned IDX_W       = $clog2(QUEUE_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [QUEUE_DEPTH-1:0] wr_sel,
    output logic [IDX_W-1:0]       wr_idx,
    input  logic                   rd_en,
    input  logic [QUEUE_DEPTH-1:0] rd_sel,
    output logic [QUEUE_DEPTH-1:0] status,
    output logic [IDX_W:0]         count,
    output logic                   wr_done,
    output logic [IDX_W-1:0]       done_idx,
    output logic                   rd_err,
    input  logic                   err_clr
);

    localparam int unsigned CNT_W = IDX_W + 1;

    // Registered state
    logic [IDX_W-1:0]       ptr;

    // Next-state values
    logic [QUEUE_DEPTH-1:0] status_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [IDX_W-1:0]       ptr_nxt;
    logic                   wr_done_nxt;
    logic [IDX_W-1:0]       done_idx_nxt;
    logic                   rd_err_nxt;

    // Slot search and handshake terms
    logic [QUEUE_DEPTH-1:0] grant_sel;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_found;
    int unsigned            cand;
    logic                   accept;
    logic                   rd_onehot;
    logic                   rel_legal;
    logic                   rel_illegal;

    // Round-robin search for the first free slot starting at ptr (registered status only)
    always_comb begin
        grant_sel   = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = 0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= QUEUE_DEPTH) begin
                cand = cand - QUEUE_DEPTH;
            end
            if (!grant_found && !status[IDX_W'(cand)]) begin
                grant_found               = 1'b1;
                grant_sel[IDX_W'(cand)]   = 1'b1;
                grant_idx                 = IDX_W'(cand);
            end
        end
    end

    assign wr_ready = ~&status;
    assign wr_sel   = grant_sel;
    assign wr_idx   = grant_idx;

    // Handshake and release-legality decode
    always_comb begin
        accept      = wr_valid & wr_ready;
        rd_onehot   = (rd_sel != '0) && ((rd_sel & (rd_sel - QUEUE_DEPTH'(1))) == '0);
        rel_legal   = rd_en & rd_onehot & (|(rd_sel & status));
        rel_illegal = rd_en & ~rel_legal;
    end

    // Next-state computation for bitmap, count, pointer, done pulse and error flag
    always_comb begin
        status_nxt   = status;
        count_nxt    = count;
        ptr_nxt      = ptr;
        wr_done_nxt  = 1'b0;
        done_idx_nxt = done_idx;
        rd_err_nxt   = rd_err;

        // Write and read slots never collide: one is free, the other occupied
        if (rel_legal) begin
            status_nxt = status_nxt & ~rd_sel;
        end
        if (accept) begin
            status_nxt   = status_nxt | grant_sel;
            wr_done_nxt  = 1'b1;
            done_idx_nxt = grant_idx;
            if (grant_idx == IDX_W'(QUEUE_DEPTH - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = grant_idx + IDX_W'(1);
            end
        end

        case ({accept, rel_legal})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        // A new illegal release wins over a coincident clear
        if (rel_illegal) begin
            rd_err_nxt = 1'b1;
        end else if (err_clr) begin
            rd_err_nxt = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status   <= '0;
            count    <= '0;
            ptr      <= '0;
            wr_done  <= 1'b0;
            done_idx <= '0;
            rd_err   <= 1'b0;
        end else begin
            status   <= status_nxt;
            count    <= count_nxt;
            ptr      <= ptr_nxt;
            wr_done  <= wr_done_nxt;
            done_idx <= done_idx_nxt;
            rd_err   <= rd_err_nxt;
        end
    end

endmodule

// File: doc/queue_slot_alloc.md
# queue_slot_alloc

Write-side slot manager for the slot-based queue. It owns the occupancy bitmap `status`, which the read-side empty/full/valid flag logic consumes. Writers issue allocation requests. The block picks a free slot round-robin, presents it one-hot on `wr_sel` so storage captures data at the same edge, and sets its status bit. Reads release slots by a one-hot `rd_sel` with `rd_en`.

## Interface
- `QUEUE_DEPTH`, default `` `QUEUE_DEPTH `` (8): number of slots, must be ≥ 2.
- `IDX_W`, default `$clog2(QUEUE_DEPTH)`: slot index width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `wr_valid` in 1: write/allocation request.
- `wr_ready` out 1: a slot is free; combinational, `~&status`.
- `wr_sel` out QUEUE_DEPTH: one-hot slot granted this cycle; combinational, all-zero when full.
- `wr_idx` out IDX_W: binary index of `wr_sel`; 0 when full.
- `rd_en` in 1: release request.
- `rd_sel` in QUEUE_DEPTH: one-hot slot to release.
- `status` out QUEUE_DEPTH: registered occupancy bitmap; 1 means the slot is occupied.
- `count` out IDX_W+1: registered number of occupied slots.
- `wr_done` out 1: registered pulse, one cycle after an accepted write.
- `done_idx` out IDX_W: index written, valid while `wr_done` is high.
- `rd_err` out 1: sticky illegal-release flag.
- `err_clr` in 1: synchronous clear of `rd_err`.

## Operation
- Reset (async assert, sync release ok): `status`=0, `count`=0, `ptr`=0, `wr_done`=0, `done_idx`=0, `rd_err`=0.
- Internal `ptr` (IDX_W) is the round-robin search start.
- Slot selection: the first index k in ptr, ptr+1, … ptr+DEPTH-1 (mod DEPTH) with `status[k]`=0.
  - Search uses only the registered `status`.
  - A slot freed by `rd_en` in the same cycle is not visible until the next cycle.
- Accept: `wr_valid & wr_ready`.
  - On the edge, `status[k]`←1, `ptr`←(k+1) mod DEPTH, `wr_done`←1, `done_idx`←k.
  - With no accept: `wr_done`←0; `ptr` and `done_idx` hold.
- `wr_valid` while full: no accept, no state change, no error. The writer holds the request.
- Release legality: `rd_en` is legal iff `rd_sel` is one-hot and `(rd_sel & status)!=0`.
  - Legal release: the bit clears at the edge.
  - Illegal release (zero, multi-hot, or targeting a free slot): `status` unchanged, `rd_err`←1.
- Simultaneous accept and legal release:
  - Both apply; the slots always differ because the write slot is free and the read slot occupied.
  - `count` is unchanged.
- Release of the slot being allocated in the same cycle: the bit is still 0 in `status`, so this is illegal. `rd_err`←1 and the allocation still completes.
- `count`: +1 on accept only, −1 on legal release only, unchanged when both or neither occur. It must always equal popcount(`status`) and never exceeds DEPTH.
- `rd_err`: once set it holds until `err_clr`. If `err_clr` and a new illegal release coincide, set wins.
- Reset mid-operation: all state returns to reset values immediately. `wr_sel` then reflects an empty bitmap, i.e. slot 0.

## Timing
- `wr_ready`, `wr_sel` and `wr_idx` are combinational from registered `status` and `ptr` only.
  - There is no path from `wr_valid`, `rd_en` or `rd_sel` to these outputs.
- Write latency: the slot is granted in cycle N, and `status`/`count` update at the end of cycle N.
  - `wr_done` is high in cycle N+1.
- Release latency: `status` drops at the end of the `rd_en` cycle. The slot becomes allocatable from cycle N+1.
- Back-to-back accepts every cycle are supported until full. Allocation order is circular.
- Read-side flags see updated `status` one edge after the causing event.

## Test plan
- Reset, then `wr_valid` held for 4 cycles with DEPTH=4:
  - `wr_idx` is 0,1,2,3 on consecutive cycles.
  - `wr_done`/`done_idx` trail by one cycle.
  - Then `status`=4'b1111, `count`=4, `wr_ready`=0, `wr_sel`=0.
- Full queue, then `rd_en` with `rd_sel`=4'b0100:
  - Next cycle `status`=4'b1011, `count`=3, `wr_idx`=2.
  - With ptr=0, the first free slot from 0 is slot 2.
- Round-robin with 4'b0011 occupied and ptr=2: write gives slot 2; release slot 0; the next write gives slot 3, not 0.
- Full queue, same cycle `wr_valid`=1 and legal release of slot 1:
  - No accept that cycle.
  - Next cycle `wr_ready`=1, `wr_idx`=1, `count`=3.
  - Accept then gives `count`=4.
- Illegal releases:
  - `rd_sel`=4'b0110 sets `rd_err`=1 with `status` unchanged.
  - `rd_sel` targeting a free slot sets `rd_err`=1.
  - `err_clr` clears it; `err_clr` coinciding with a new illegal release leaves `rd_err`=1.
- Reset mid-operation:
  - With `status`=4'b0111 and `wr_valid` high, deassert `reset_n` between edges.
  - `status`, `count` and `wr_done` go to 0 immediately.
  - After release the first grant is slot 0.
